// File: rtl/color_classify.sv
// color_classify
//   Classifies raw R/G/B sensor counts as NONE, RED, GREEN, BLUE or DARK.
//   The class is debounced over PERSIST agreeing samples. The block then
//   drives the legacy per-colour valid flags, a class code, a one-cycle
//   change pulse and a GRB word for a WS2812 LED driver.
//
// Ports
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   in_valid    in   sample present on r/g/b_data
//   in_ready    out  block can accept a sample (high only in S_IDLE)
//   r_data      in   red channel count   [DATA_W-1:0]
//   g_data      in   green channel count [DATA_W-1:0]
//   b_data      in   blue channel count  [DATA_W-1:0]
//   class_code  out  0 NONE, 1 RED, 2 GREEN, 3 BLUE, 4 DARK
//   class_chg   out  one-cycle pulse when class_code changes
//   r_valid     out  class_code == RED
//   g_valid     out  class_code == GREEN
//   b_valid     out  class_code == BLUE
//   led_grb     out  {G,R,B} colour word
module color_classify #(
  parameter int         DATA_W  = 16,
  parameter int         MARGIN  = 64,
  parameter int         DARK_TH = 100,
  parameter int         PERSIST = 4,
  parameter logic [7:0] BRIGHT  = 8'h20
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [DATA_W-1:0] g_data,
  input  logic [DATA_W-1:0] b_data,
  output logic [2:0]        class_code,
  output logic              class_chg,
  output logic              r_valid,
  output logic              g_valid,
  output logic              b_valid,
  output logic [23:0]       led_grb
);

  localparam int              CNT_W    = $clog2(PERSIST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERSIST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DATA_W:0] MARGIN_X = (DATA_W + 1)'(MARGIN);
  localparam logic [DATA_W-1:0] DARK_X = DATA_W'(DARK_TH);
  localparam logic [7:0]      DIM      = BRIGHT >> 2;

  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_RED   = 3'd1,
    C_GREEN = 3'd2,
    C_BLUE  = 3'd3,
    C_DARK  = 3'd4
  } cls_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_UPD
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] g_q;
  logic [DATA_W-1:0] b_q;
  cls_t              cand_comb;
  cls_t              cand_q;
  cls_t              pending;
  cls_t              class_q;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              fire;

  function automatic logic [23:0] led_for(input cls_t c);
    case (c)
      C_RED:   led_for = {8'h00, BRIGHT, 8'h00};
      C_GREEN: led_for = {BRIGHT, 8'h00, 8'h00};
      C_BLUE:  led_for = {8'h00, 8'h00, BRIGHT};
      C_DARK:  led_for = {DIM, DIM, DIM};
      default: led_for = 24'h000000;
    endcase
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_CMP;
      end
      S_CMP:   state_nxt = S_UPD;
      S_UPD:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sample capture; later changes on the input bus are ignored.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (state == S_IDLE && in_valid) begin
      r_q <= r_data;
      g_q <= g_data;
      b_q <= b_data;
    end
  end

  // Margin sums use one extra bit so a bright channel plus MARGIN never
  // wraps around and lets a smaller channel win.
  always_comb begin
    logic [DATA_W:0] rx, gx, bx;
    rx = {1'b0, r_q};
    gx = {1'b0, g_q};
    bx = {1'b0, b_q};
    cand_comb = C_NONE;
    if (r_q < DARK_X && g_q < DARK_X && b_q < DARK_X)
      cand_comb = C_DARK;
    else if (rx > gx + MARGIN_X && rx > bx + MARGIN_X)
      cand_comb = C_RED;
    else if (gx > rx + MARGIN_X && gx > bx + MARGIN_X)
      cand_comb = C_GREEN;
    else if (bx > rx + MARGIN_X && bx > gx + MARGIN_X)
      cand_comb = C_BLUE;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)          cand_q <= C_NONE;
    else if (state == S_CMP) cand_q <= cand_comb;
  end

  // Run length of identical candidates, saturating at PERSIST so a long
  // run cannot produce a second change pulse.
  always_comb begin
    count_nxt = CNT_ONE;
    if (cand_q == pending)
      count_nxt = (count == CNT_MAX) ? CNT_MAX : count + CNT_ONE;
    fire = (count_nxt == CNT_MAX) && (cand_q != class_q);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending   <= C_NONE;
      count     <= '0;
      class_q   <= C_NONE;
      class_chg <= 1'b0;
      r_valid   <= 1'b0;
      g_valid   <= 1'b0;
      b_valid   <= 1'b0;
      led_grb   <= 24'h000000;
    end else begin
      class_chg <= 1'b0;
      if (state == S_UPD) begin
        pending <= cand_q;
        count   <= count_nxt;
        if (fire) begin
          class_q   <= cand_q;
          class_chg <= 1'b1;
          r_valid   <= (cand_q == C_RED);
          g_valid   <= (cand_q == C_GREEN);
          b_valid   <= (cand_q == C_BLUE);
          led_grb   <= led_for(cand_q);
        end
      end
    end
  end

  assign class_code = class_q;

endmodule

// File: tb/tb_color_classify.sv
// tb_color_classify
//   Self-checking bench for color_classify with default parameters.
//   A reference model classifies each accepted sample with integer
//   arithmetic and decides class changes from the history of candidates.
module tb_color_classify;

  localparam int P = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] r_data = '0;
  logic [15:0] g_data = '0;
  logic [15:0] b_data = '0;
  logic [2:0]  class_code;
  logic        class_chg;
  logic        r_valid;
  logic        g_valid;
  logic        b_valid;
  logic [23:0] led_grb;

  int total = 0;
  int bad = 0;

  int model_class = 0;
  bit exp_chg = 0;
  int hist[$];
  logic mid_ready;
  logic mid_chg;
  int run_kind = 0;
  int run_left = 0;

  color_classify dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .class_code(class_code), .class_chg(class_chg),
    .r_valid(r_valid), .g_valid(g_valid), .b_valid(b_valid),
    .led_grb(led_grb)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int classify(input int r, input int g, input int b);
    if (r < 100 && g < 100 && b < 100) return 4;
    if (r > g + 64 && r > b + 64) return 1;
    if (g > r + 64 && g > b + 64) return 2;
    if (b > r + 64 && b > g + 64) return 3;
    return 0;
  endfunction

  function automatic logic [23:0] exp_led(input int c);
    case (c)
      1: return 24'h002000;
      2: return 24'h200000;
      3: return 24'h000020;
      4: return 24'h080808;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic void model_step(input int r, input int g, input int b);
    int c;
    bit all_same;
    c = classify(r, g, b);
    hist.push_back(c);
    if (hist.size() > P) void'(hist.pop_front());
    exp_chg = 0;
    if (hist.size() == P) begin
      all_same = 1;
      foreach (hist[i]) if (hist[i] != c) all_same = 0;
      if (all_same && c != model_class) begin
        model_class = c;
        exp_chg = 1;
      end
    end
  endfunction

  function automatic void model_reset();
    hist.delete();
    model_class = 0;
    exp_chg = 0;
  endfunction

  // Handshakes one sample, then returns on the negedge after the
  // results are due. With hold set, in_valid stays high with junk data
  // while the block is busy; the caller must send the next sample at once.
  task automatic drive_sample(input int r, input int g, input int b, input bit hold);
    int waits = 0;
    while (in_ready !== 1'b1 && waits < 10) begin
      @(negedge sys_clk);
      waits++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_timeout got=%b exp=1", in_ready);
    end
    r_data = 16'(r);
    g_data = 16'(g);
    b_data = 16'(b);
    in_valid = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    in_valid = hold;
    r_data = 16'($urandom);
    g_data = 16'($urandom);
    b_data = 16'($urandom);
    mid_ready = in_ready;
    mid_chg = class_chg;
    @(negedge sys_clk);
    @(negedge sys_clk);
    model_step(r, g, b);
  endtask

  task automatic gen_sample(output int r, output int g, output int b);
    int big;
    int base;
    if (run_left == 0) begin
      run_kind = $urandom_range(0, 6);
      run_left = $urandom_range(1, 6);
    end
    run_left--;
    big = $urandom_range(200, 65535);
    base = $urandom_range(100, 65000);
    r = $urandom_range(0, 65535);
    g = $urandom_range(0, 65535);
    b = $urandom_range(0, 65535);
    case (run_kind)
      0: begin r = big; g = $urandom_range(0, big); b = $urandom_range(0, big); end
      1: begin g = big; r = $urandom_range(0, big); b = $urandom_range(0, big); end
      2: begin b = big; r = $urandom_range(0, big); g = $urandom_range(0, big); end
      3: begin r = base + $urandom_range(64, 65); g = base; b = $urandom_range(0, base); end
      4: begin r = $urandom_range(0, 100); g = $urandom_range(0, 100); b = $urandom_range(0, 100); end
      5: begin r = 65535; g = 65535 - $urandom_range(0, 70); b = 0; end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;
    in_valid = 1'b1;
    r_data = 16'd1000; g_data = 16'd200; b_data = 16'd200;
    repeat (2) @(negedge sys_clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=1", in_ready); end
    total++; if (class_code !== 3'd0) begin bad++; $display("[TB] FAIL reset_class got=%0d exp=0", class_code); end
    total++; if (led_grb !== 24'h0) begin bad++; $display("[TB] FAIL reset_led got=%h exp=000000", led_grb); end
    total++; if (class_chg !== 1'b0) begin bad++; $display("[TB] FAIL reset_chg got=%b exp=0", class_chg); end
    total++; if ({r_valid, g_valid, b_valid} !== 3'b000) begin bad++; $display("[TB] FAIL reset_valids got=%b exp=000", {r_valid, g_valid, b_valid}); end
    in_valid = 1'b0;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    total++; if (in_ready !== 1'b1 || class_code !== 3'd0) begin bad++; $display("[TB] FAIL reset_release got=%b/%0d exp=1/0", in_ready, class_code); end
    model_reset();
  endtask

  task automatic test_red_persist();
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      drive_sample(1000, 200, 200, 0);
      pulses += int'(class_chg);
      total++; if (class_chg !== (i == 3)) begin bad++; $display("[TB] FAIL red_chg_%0d got=%b exp=%b", i, class_chg, i == 3); end
    end
    total++; if (class_code !== 3'd1) begin bad++; $display("[TB] FAIL red_class got=%0d exp=1", class_code); end
    total++; if ({r_valid, g_valid, b_valid} !== 3'b100) begin bad++; $display("[TB] FAIL red_valids got=%b exp=100", {r_valid, g_valid, b_valid}); end
    total++; if (led_grb !== 24'h002000) begin bad++; $display("[TB] FAIL red_led got=%h exp=002000", led_grb); end
    @(negedge sys_clk);
    total++; if (class_chg !== 1'b0) begin bad++; $display("[TB] FAIL red_pulse_width got=%b exp=0", class_chg); end
    total++; if (pulses != 1) begin bad++; $display("[TB] FAIL red_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_margin();
    for (int i = 0; i < 4; i++) begin
      drive_sample(500, 450, 0, 0);
      total++; if (class_code !== ((i < 3) ? 3'd1 : 3'd0)) begin bad++; $display("[TB] FAIL margin_class_%0d got=%0d exp=%0d", i, class_code, (i < 3) ? 1 : 0); end
    end
    total++; if (led_grb !== 24'h0) begin bad++; $display("[TB] FAIL margin_led got=%h exp=000000", led_grb); end
    total++; if (r_valid !== 1'b0) begin bad++; $display("[TB] FAIL margin_rvalid got=%b exp=0", r_valid); end
  endtask

  task automatic test_restart();
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) drive_sample(0, 0, 1000, 0);
      else        drive_sample(1000, 200, 200, 0);
      pulses += int'(class_chg);
      total++; if (class_chg !== (i == 7)) begin bad++; $display("[TB] FAIL restart_chg_%0d got=%b exp=%b", i, class_chg, i == 7); end
    end
    total++; if (pulses != 1 || class_code !== 3'd1) begin bad++; $display("[TB] FAIL restart_final got=%0d/%0d exp=1/1", pulses, class_code); end
  endtask

  task automatic test_dark_sat();
    for (int i = 0; i < 4; i++) drive_sample(50, 50, 50, 0);
    total++; if (class_code !== 3'd4) begin bad++; $display("[TB] FAIL dark_class got=%0d exp=4", class_code); end
    total++; if (led_grb !== 24'h080808) begin bad++; $display("[TB] FAIL dark_led got=%h exp=080808", led_grb); end
    total++; if ({r_valid, g_valid, b_valid} !== 3'b000) begin bad++; $display("[TB] FAIL dark_valids got=%b exp=000", {r_valid, g_valid, b_valid}); end
    for (int i = 0; i < 4; i++) drive_sample(65535, 65535, 65535, 0);
    total++; if (class_code !== 3'd0) begin bad++; $display("[TB] FAIL sat_class got=%0d exp=0", class_code); end
    total++; if (led_grb !== 24'h0) begin bad++; $display("[TB] FAIL sat_led got=%h exp=000000", led_grb); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) drive_sample(1000, 200, 200, 0);
    r_data = 16'd1000; g_data = 16'd200; b_data = 16'd200;
    in_valid = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge sys_clk);
    total++; if (class_code !== 3'd0 || class_chg !== 1'b0) begin bad++; $display("[TB] FAIL midrst_class got=%0d/%b exp=0/0", class_code, class_chg); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_ready got=%b exp=1", in_ready); end
    sys_rst_n = 1'b1;
    model_reset();
    @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      drive_sample(1000, 200, 200, 0);
      total++; if (class_chg !== (i == 3)) begin bad++; $display("[TB] FAIL midrst_chg_%0d got=%b exp=%b", i, class_chg, i == 3); end
    end
    total++; if (class_code !== 3'd1) begin bad++; $display("[TB] FAIL midrst_final got=%0d exp=1", class_code); end
  endtask

  task automatic test_back_to_back();
    int r, g, b;
    for (int i = 0; i < 150; i++) begin
      gen_sample(r, g, b);
      drive_sample(r, g, b, i != 149);
      total++; if (mid_ready !== 1'b0 || mid_chg !== 1'b0) begin bad++; $display("[TB] FAIL b2b_mid_%0d got=%b%b exp=00", i, mid_ready, mid_chg); end
      total++; if (class_code !== 3'(model_class) || class_chg !== exp_chg) begin bad++; $display("[TB] FAIL b2b_class_%0d got=%0d/%b exp=%0d/%b", i, class_code, class_chg, model_class, exp_chg); end
      total++; if (led_grb !== exp_led(model_class)) begin bad++; $display("[TB] FAIL b2b_led_%0d got=%h exp=%h", i, led_grb, exp_led(model_class)); end
      total++; if ({r_valid, g_valid, b_valid} !== {model_class == 1, model_class == 2, model_class == 3}) begin bad++; $display("[TB] FAIL b2b_valids_%0d got=%b class=%0d", i, {r_valid, g_valid, b_valid}, model_class); end
    end
  endtask

  task automatic test_random();
    int r, g, b;
    for (int i = 0; i < 150; i++) begin
      gen_sample(r, g, b);
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
      drive_sample(r, g, b, 0);
      total++; if (mid_ready !== 1'b0 || mid_chg !== 1'b0) begin bad++; $display("[TB] FAIL rnd_mid_%0d got=%b%b exp=00", i, mid_ready, mid_chg); end
      total++; if (class_code !== 3'(model_class) || class_chg !== exp_chg) begin bad++; $display("[TB] FAIL rnd_class_%0d got=%0d/%b exp=%0d/%b", i, class_code, class_chg, model_class, exp_chg); end
      total++; if (led_grb !== exp_led(model_class)) begin bad++; $display("[TB] FAIL rnd_led_%0d got=%h exp=%h", i, led_grb, exp_led(model_class)); end
      total++; if ({r_valid, g_valid, b_valid} !== {model_class == 1, model_class == 2, model_class == 3}) begin bad++; $display("[TB] FAIL rnd_valids_%0d got=%b class=%0d", i, {r_valid, g_valid, b_valid}, model_class); end
    end
  endtask

  initial begin
    $display("[TB] starting color_classify bench");
    test_reset();
    test_red_persist();
    test_margin();
    test_restart();
    test_dark_sat();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/color_classify.md
Name: color_classify

Overview:
- Parametrised successor to the single-bit colour-valid path between the colour-sensor front end and the WS2812 driver.
- Accepts raw R/G/B channel counts through a valid/ready handshake.
- Classifies each sample as NONE, RED, GREEN, BLUE or DARK using a margin test and a darkness threshold.
- Debounces the class over PERSIST consecutive agreeing samples, then drives the legacy r/g/b_valid flags, a class code, a change pulse and a 24-bit GRB word for the LED driver.

Parameters:
DATA_W, 16, width of each raw channel count
MARGIN, 64, amount by which the winning channel must exceed both other channels (DATA_W bits)
DARK_TH, 100, all three channels below this value -> DARK (DATA_W bits)
PERSIST, 4, consecutive identical candidates required before the output class changes (>=1)
BRIGHT, 8'h20, LED intensity byte used in led_grb

Ports:
sys_clk  in  1  system clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample present on r/g/b_data
in_ready  out  1  block can accept a sample
r_data  in  DATA_W  red channel count
g_data  in  DATA_W  green channel count
b_data  in  DATA_W  blue channel count
class_code  out  3  current class: 0 NONE, 1 RED, 2 GREEN, 3 BLUE, 4 DARK
class_chg  out  1  one-cycle pulse when class_code changes
r_valid  out  1  class_code==RED
g_valid  out  1  class_code==GREEN
b_valid  out  1  class_code==BLUE
led_grb  out  24  {G,R,B} colour word for the WS2812 driver

Behaviour:
- Reset (async assert, sync-safe release):
  - FSM returns to S_IDLE; in_ready=1.
  - class_code=NONE, class_chg=0, r/g/b_valid=0, led_grb=0.
  - Pending candidate=NONE, persistence count=0.
  - Reset mid-sample discards the sample with no partial update.
- FSM:
  - S_IDLE: in_ready=1. On in_valid&&in_ready, register r/g/b_data and go to S_CMP.
  - S_CMP: in_ready=0. Compute the candidate into a register; go to S_UPD.
  - S_UPD: in_ready=0. Update pending, count, class and outputs; go to S_IDLE.
- Throughput and latency:
  - One sample per 3 cycles.
  - Sample accepted at edge T -> outputs and class_chg visible after edge T+2.
  - in_ready returns high after edge T+2.
- Candidate rules, in priority order:
  - r<DARK_TH && g<DARK_TH && b<DARK_TH -> DARK.
  - Otherwise, channel X wins if X > Y+MARGIN and X > Z+MARGIN. Additions are done in DATA_W+1 bits, so there is no wrap and a sum may exceed the max count.
  - Otherwise NONE, which covers ties and insufficient margin.
- Persistence, in S_UPD:
  - If candidate==pending: count=min(count+1, PERSIST).
  - Otherwise: pending=candidate, count=1.
  - If the new count==PERSIST and pending!=class_code: class_code=pending, class_chg=1 for exactly one cycle.
  - PERSIST=1 gives an immediate class change on the first sample.
  - Saturated count plus a repeated candidate produces no further pulse.
  - Count width is clog2(PERSIST+1).
- Outputs registered, derived from class_code:
  - RED: led_grb={8'h00,BRIGHT,8'h00}.
  - GREEN: led_grb={BRIGHT,8'h00,8'h00}.
  - BLUE: led_grb={8'h00,8'h00,BRIGHT}.
  - DARK: led_grb={3{BRIGHT>>2}}, a dim white.
  - NONE: led_grb=24'h0.
  - r/g/b_valid are mutually exclusive and never high together.
- in_valid while in_ready=0 is ignored. The producer must hold the sample until the handshake.
- Input data changing after acceptance has no effect.

Test Plan:
- Reset with in_valid=1 -> in_ready=1, class_code=0, led_grb=0, no class_chg.
- Four samples r=1000,g=200,b=200 (PERSIST=4) -> class_chg exactly once, 2 cycles after the 4th accept. class_code=1, r_valid=1, led_grb=24'h002000.
- Samples r=500,g=450,b=0 (margin 50<64) -> candidate NONE. Class stays at its prior value until 4 NONE samples, then class_code=0, led_grb=0.
- RED x3, BLUE x1, RED x4 -> no change until the 8th sample, because the count restarts after BLUE. One class_chg to RED total.
- All channels 50 x4 -> class_code=4, led_grb=24'h080808. r=g=b=16'hFFFF x4 -> NONE (no overflow win).
- Assert sys_rst_n low in S_CMP with a RED sample -> after release, class_code=0, in_ready=1. The next accepted sample starts count=1.
